copi_frame_scheduler: RTL
=========================

Name: copi_frame_scheduler

Overview:
- Chooses the 16-bit COPI command word for each of the 35 serial cycles in a frame, on behalf of the serial/acquisition core.
- Three word sources:
  - the steady-state command list from the control registers;
  - a PS-fed one-shot auxiliary command queue;
  - an auto-generated calibration sequence (CALIBRATE followed by dummy frames).
- Sits between the AXI control-register block and the serial engine.
- Auxiliary traffic is only allowed in the auxiliary slot window, so it never disturbs channel-convert slots.

Parameters:
- N_SLOTS, 35, serial cycles per frame (slot_idx range 0..N_SLOTS-1)
- AUX_FIRST, 32, first slot index of the auxiliary window
- AUX_LAST, 34, last slot index of the auxiliary window (AUX_FIRST<=AUX_LAST<N_SLOTS)
- AUX_DEPTH, 16, auxiliary queue depth in words (power of two)
- CAL_FRAMES, 9, dummy frames after the CALIBRATE word

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- run  in  1  transmission_active from the core; 0 forces the scheduler idle
- list_words  in  16*36  steady-state command list; word k = list_words[16k+:16]
- slot_req  in  1  one-cycle request for the word of slot slot_idx
- slot_idx  in  6  slot being requested
- word_valid  out  1  response strobe, exactly one cycle after slot_req
- word  out  16  COPI word for the requested slot
- word_src  out  2  source of word: 0 list, 1 aux, 2 cal, 3 idle-zero
- aux_push  in  1  write aux_data into the auxiliary queue
- aux_data  in  16  auxiliary command word
- aux_full  out  1  queue holds AUX_DEPTH words
- aux_count  out  $clog2(AUX_DEPTH)+1  queue occupancy
- aux_flush  in  1  empty the queue
- cal_word  in  16  CALIBRATE command word
- dummy_word  in  16  dummy command word used during calibration
- cal_req  in  1  one-cycle pulse requesting a calibration sequence
- cal_busy  out  1  calibration armed or running
- aux_overflow  out  1  sticky: push attempted while full; cleared by aux_flush or rst

Behaviour:
- Reset values:
  - word_valid=0, word=0, word_src=3, aux_full=0, aux_count=0, cal_busy=0, aux_overflow=0
  - state=S_IDLE, queue empty
- Latency: word_valid and word follow slot_req by exactly 1 clk. Requests are never back-pressured.
- A request with slot_idx>=N_SLOTS returns word=0, word_src=3.
- States:
  - S_IDLE: every response is 0/src 3.
    - run=1 -> S_RUN.
    - cal_req while idle is latched (cal_busy=1) and the machine goes S_IDLE -> S_CAL_ARM once run=1.
  - S_RUN: slots outside the aux window return list_words[slot_idx], src 0. Aux-window slots:
    - queue non-empty: pop the head, return it, src 1;
    - queue empty: return list_words[slot_idx], src 0.
    - cal_req -> S_CAL_ARM.
  - S_CAL_ARM: behaves like S_RUN until a slot_req with slot_idx==0 arrives. On that request the machine enters S_CAL with cal_frm=0.
  - S_CAL:
    - Aux-window slots, frame 0: slot AUX_FIRST gets cal_word (src 2); the other window slots get dummy_word (src 2).
    - Aux-window slots, frames 1..CAL_FRAMES: dummy_word (src 2).
    - Non-window slots still return list words.
    - The aux queue is not popped during S_CAL.
    - A slot_req with slot_idx==0 increments cal_frm. When cal_frm reaches CAL_FRAMES+1, the machine goes to S_RUN and cal_busy falls. That slot-0 request is served from S_RUN.
- run falling in any state:
  - next state is S_IDLE;
  - an in-progress calibration is abandoned and cal_busy=0;
  - the queue contents are retained.
- cal_req while cal_busy=1 is ignored.
- Queue:
  - push when full is dropped and sets aux_overflow;
  - push and pop in the same cycle keep aux_count unchanged, including when full;
  - aux_flush has priority over push and pop in the same cycle. It leaves count=0 and clears aux_overflow.
- aux_full = (aux_count==AUX_DEPTH). Pointers wrap modulo AUX_DEPTH.

Optional Feature:
- SCHED_STATS_EN defined:
  - adds outputs stat_aux_sent[31:0], stat_cal_runs[31:0], stat_list_sent[31:0];
  - each counter wraps, increments on word_valid with the matching word_src, and clears on rst;
  - stat_cal_runs increments on S_CAL entry.
- Undefined: the ports and counters do not exist.

Decomposition:
- Package copi_sched_pkg:
  - state enum (S_IDLE, S_RUN, S_CAL_ARM, S_CAL);
  - word_src encodings SRC_LIST/SRC_AUX/SRC_CAL/SRC_IDLE;
  - default slot/window constants.
- One sub-module: copi_aux_fifo. It is a synchronous FIFO with push/pop/flush, count, full and an overflow flag.

Test Plan:
- run=1, list_words word k=16'h0100+k, empty queue; request slots 0..34 -> each word=16'h0100+idx, src 0, valid 1 clk after each request.
- Push 16'hA001, 16'hA002; run one frame -> slot32=A001 src1, slot33=A002 src1, slot34=list word 16'h0122 src0; aux_count goes to 0.
- cal_req at slot 10, cal_word=16'h5500, dummy_word=16'hE800 -> rest of current frame unchanged. Next frame slot32=5500, slots33-34=E800, then 9 frames of window=E800. cal_busy drops exactly at the slot-0 request of the 11th frame.
- Push 17 words at AUX_DEPTH=16 -> aux_full=1 after 16 pushes, aux_overflow=1; aux_flush -> count=0, overflow=0.
- Drop run mid-calibration at frame 4 -> cal_busy=0, next responses word=0 src3. Re-assert run -> normal list words, no calibration.
- Simultaneous push and pop at full -> count stays 16, popped word is the oldest, no overflow.

Source files
------------

// File: rtl/copi_sched_pkg.sv
// Shared types and default constants for the COPI frame scheduler.
package copi_sched_pkg;
  localparam int SLOT_W       = 6;
  localparam int WORD_W       = 16;
  localparam int LIST_WORDS   = 36;
  localparam int N_SLOTS_D    = 35;
  localparam int AUX_FIRST_D  = 32;
  localparam int AUX_LAST_D   = 34;
  localparam int AUX_DEPTH_D  = 16;
  localparam int CAL_FRAMES_D = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_CAL_ARM = 2'd2,
    S_CAL     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_LIST = 2'd0,
    SRC_AUX  = 2'd1,
    SRC_CAL  = 2'd2,
    SRC_IDLE = 2'd3
  } src_t;

  function automatic logic in_window(input logic [SLOT_W-1:0] idx,
                                     input int first, input int last);
    return (int'(idx) >= first) && (int'(idx) <= last);
  endfunction
endpackage

// File: rtl/copi_aux_fifo.sv
// Auxiliary command queue: synchronous FIFO with flush, occupancy and sticky overflow.
module copi_aux_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DATA_W-1:0]        o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_overflow;
  logic              w_do_pop;
  logic              w_do_push;

  assign o_full     = (r_count == CW'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_overflow = r_overflow;
  assign o_head     = r_mem[r_rd_ptr];

  // A pop in the same cycle frees a slot, so a push at full still lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (i_push && !w_do_push) r_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/copi_frame_scheduler.sv
// Per-slot COPI command word selection: list, aux queue, or calibration sequence.
// Optional statistics counters are built when SCHED_STATS_EN is defined.
module copi_frame_scheduler
  import copi_sched_pkg::*;
#(
  parameter int N_SLOTS    = N_SLOTS_D,
  parameter int AUX_FIRST  = AUX_FIRST_D,
  parameter int AUX_LAST   = AUX_LAST_D,
  parameter int AUX_DEPTH  = AUX_DEPTH_D,
  parameter int CAL_FRAMES = CAL_FRAMES_D
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic [WORD_W*LIST_WORDS-1:0]  list_words,
  input  logic                          slot_req,
  input  logic [SLOT_W-1:0]             slot_idx,
  output logic                          word_valid,
  output logic [WORD_W-1:0]             word,
  output logic [1:0]                    word_src,
  input  logic                          aux_push,
  input  logic [WORD_W-1:0]             aux_data,
  output logic                          aux_full,
  output logic [$clog2(AUX_DEPTH):0]    aux_count,
  input  logic                          aux_flush,
  input  logic [WORD_W-1:0]             cal_word,
  input  logic [WORD_W-1:0]             dummy_word,
  input  logic                          cal_req,
  output logic                          cal_busy,
`ifdef SCHED_STATS_EN
  output logic [31:0]                   stat_aux_sent,
  output logic [31:0]                   stat_cal_runs,
  output logic [31:0]                   stat_list_sent,
`endif
  output logic                          aux_overflow
);
  localparam int FW = $clog2(CAL_FRAMES + 2);

  state_t            r_state;
  state_t            w_next;
  logic [FW-1:0]     r_cal_frm;
  logic              r_cal_pend;
  logic              r_vld_p1;
  logic [WORD_W-1:0] r_word_p1;
  src_t              r_src_p1;

  logic [WORD_W-1:0] w_word;
  src_t              w_src;
  logic              w_pop;
  logic              w_idx_ok;
  logic              w_in_win;
  logic              w_slot0;
  logic [WORD_W-1:0] w_list_word;
  logic [WORD_W-1:0] w_aux_head;
  logic              w_aux_empty;

  assign w_idx_ok    = (slot_idx < SLOT_W'(N_SLOTS));
  assign w_in_win    = in_window(slot_idx, AUX_FIRST, AUX_LAST);
  assign w_slot0     = slot_req && (slot_idx == '0);
  assign w_list_word = list_words[slot_idx*WORD_W +: WORD_W];

  copi_aux_fifo #(
    .DEPTH  (AUX_DEPTH),
    .DATA_W (WORD_W)
  ) u_aux_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (aux_push),
    .i_data     (aux_data),
    .i_pop      (w_pop),
    .i_flush    (aux_flush),
    .o_head     (w_aux_head),
    .o_count    (aux_count),
    .o_full     (aux_full),
    .o_empty    (w_aux_empty),
    .o_overflow (aux_overflow)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cal_frm  <= '0;
      r_cal_pend <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_CAL_ARM && w_next == S_CAL)
        r_cal_frm <= '0;
      else if (r_state == S_CAL && w_slot0)
        r_cal_frm <= r_cal_frm + 1'b1;
      // A request seen while stopped waits for run; leaving idle consumes it.
      r_cal_pend <= (r_state == S_IDLE && w_next == S_IDLE) ? (r_cal_pend | cal_req) : 1'b0;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (run) w_next = (r_cal_pend || cal_req) ? S_CAL_ARM : S_RUN;
      S_RUN:     if (cal_req) w_next = S_CAL_ARM;
      S_CAL_ARM: if (w_slot0) w_next = S_CAL;
      S_CAL:     if (w_slot0 && r_cal_frm == FW'(CAL_FRAMES)) w_next = S_RUN;
      default:   w_next = S_IDLE;
    endcase
    if (!run) w_next = S_IDLE;
  end

  always_comb begin
    w_word   = '0;
    w_src    = SRC_IDLE;
    w_pop    = 1'b0;
    cal_busy = r_cal_pend || (r_state == S_CAL_ARM) || (r_state == S_CAL);
    if (slot_req && run && r_state != S_IDLE && w_idx_ok) begin
      w_word = w_list_word;
      w_src  = SRC_LIST;
      if (w_in_win) begin
        if (r_state == S_CAL) begin
          w_src  = SRC_CAL;
          w_word = (r_cal_frm == '0 && slot_idx == SLOT_W'(AUX_FIRST)) ? cal_word : dummy_word;
        end else if (!w_aux_empty) begin
          w_src  = SRC_AUX;
          w_word = w_aux_head;
          w_pop  = 1'b1;
        end
      end
    end
  end

  // Response stage: one cycle after the request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p1  <= 1'b0;
      r_word_p1 <= '0;
      r_src_p1  <= SRC_IDLE;
    end else begin
      r_vld_p1 <= slot_req;
      if (slot_req) begin
        r_word_p1 <= w_word;
        r_src_p1  <= w_src;
      end
    end
  end

  assign word_valid = r_vld_p1;
  assign word       = r_word_p1;
  assign word_src   = r_src_p1;

`ifdef SCHED_STATS_EN
  logic [31:0] r_stat_aux;
  logic [31:0] r_stat_cal;
  logic [31:0] r_stat_list;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_aux  <= '0;
      r_stat_cal  <= '0;
      r_stat_list <= '0;
    end else begin
      if (r_vld_p1 && r_src_p1 == SRC_AUX)  r_stat_aux  <= r_stat_aux + 32'd1;
      if (r_vld_p1 && r_src_p1 == SRC_LIST) r_stat_list <= r_stat_list + 32'd1;
      if (r_state != S_CAL && w_next == S_CAL) r_stat_cal <= r_stat_cal + 32'd1;
    end
  end

  assign stat_aux_sent  = r_stat_aux;
  assign stat_cal_runs  = r_stat_cal;
  assign stat_list_sent = r_stat_list;
`endif
endmodule
